// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared definitions for the register-file writeback arbiter.
//   prio_state_e   - priority state encoding (PRI_LSU / PRI_ALU)
//   REG_AW         - register-address width
//   STARVE_MAX_DEF - default consecutive-ALU-loss limit before a forced ALU grant
package wb_arbiter_pkg;

    localparam int unsigned REG_AW         = 5;
    localparam int unsigned STARVE_MAX_DEF = 4;

    typedef enum logic {
        PRI_LSU = 1'b0,
        PRI_ALU = 1'b1
    } prio_state_e;

endpackage : wb_arbiter_pkg

// File: rtl/wb_prio_fsm.sv
// wb_prio_fsm: ALU starvation counter and writeback priority state machine.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   alu_req     - ALU presents a valid request with rd != 0
//   lsu_req     - LSU presents a valid request with rd != 0
//   alu_grant   - ALU request granted this cycle
//   alu_pri     - 1 when the ALU wins a collision (state PRI_ALU)
//   starve_cnt  - consecutive ALU losses, saturating at STARVE_MAX
module wb_prio_fsm
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_req,
    input  logic       lsu_req,
    input  logic       alu_grant,
    output logic       alu_pri,
    output logic [3:0] starve_cnt
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    prio_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        alu_lose;

    // The ALU only loses when both channels compete for a real register.
    assign alu_lose = alu_req && lsu_req && !alu_grant;

    // Next state and next count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        // An absent ALU request (no valid, or an x0 write that completes
        // immediately) ends the losing streak, as does any ALU grant.
        if (!alu_req || alu_grant) begin
            cnt_d = 4'd0;
        end else if (alu_lose && (cnt_q != CNT_MAX)) begin
            cnt_d = 4'(cnt_q + 4'd1);
        end

        case (state_q)
            // Flip in the same edge that the count reaches the limit, so the
            // ALU wins the very next cycle.
            PRI_LSU: if (cnt_d == CNT_MAX) state_d = PRI_ALU;
            // Held until exactly one ALU grant, regardless of alu_valid.
            PRI_ALU: if (alu_grant) state_d = PRI_LSU;
            default: state_d = PRI_LSU;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRI_LSU;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alu_pri    = (state_q == PRI_ALU);
    assign starve_cnt = cnt_q;

endmodule : wb_prio_fsm

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates ALU and LSU writeback requests onto one register-file
// write port, with starvation protection for the ALU.
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   alu_valid/ready/rd/data           - ALU writeback channel
//   lsu_valid/ready/rd/data           - load-unit writeback channel
//   rf_we, rf_wa, rf_wd               - registered register-file write port
//   starve_cnt                        - consecutive ALU losses (debug)
// Optional (macro WB_ARBITER_BYPASS_EN):
//   byp_ra1/2 -> byp_hit1/2, byp_rd1/2 - combinational forward of the write
//                                         currently being committed
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [DWIDTH-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [DWIDTH-1:0] lsu_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [DWIDTH-1:0] rf_wd,
`ifdef WB_ARBITER_BYPASS_EN
    input  logic [REG_AW-1:0] byp_ra1,
    input  logic [REG_AW-1:0] byp_ra2,
    output logic [DWIDTH-1:0] byp_rd1,
    output logic [DWIDTH-1:0] byp_rd2,
    output logic              byp_hit1,
    output logic              byp_hit2,
`endif
    output logic [3:0]        starve_cnt
);

    logic alu_req, lsu_req;
    logic alu_grant, lsu_grant;
    logic alu_pri;

    // Only requests targeting a real register compete; rst masks everything.
    assign alu_req = !rst && alu_valid && (alu_rd != '0);
    assign lsu_req = !rst && lsu_valid && (lsu_rd != '0);

    assign alu_grant = alu_req && (alu_pri || !lsu_req);
    assign lsu_grant = lsu_req && (!alu_pri || !alu_req);

    // x0 writes are accepted and discarded without touching the write port.
    assign alu_ready = !rst && alu_valid && ((alu_rd == '0) || alu_grant);
    assign lsu_ready = !rst && lsu_valid && ((lsu_rd == '0) || lsu_grant);

    wb_prio_fsm #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio_fsm (
        .clk        (clk),
        .rst        (rst),
        .alu_req    (alu_req),
        .lsu_req    (lsu_req),
        .alu_grant  (alu_grant),
        .alu_pri    (alu_pri),
        .starve_cnt (starve_cnt)
    );

    // Register-file write port; address/data hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= alu_grant || lsu_grant;
            if (alu_grant) begin
                rf_wa <= alu_rd;
                rf_wd <= alu_data;
            end else if (lsu_grant) begin
                rf_wa <= lsu_rd;
                rf_wd <= lsu_data;
            end
        end
    end

`ifdef WB_ARBITER_BYPASS_EN
    // Forward the value being committed this cycle to readers of the same reg.
    assign byp_hit1 = rf_we && (rf_wa != '0) && (rf_wa == byp_ra1);
    assign byp_hit2 = rf_we && (rf_wa != '0) && (rf_wa == byp_ra2);
    assign byp_rd1  = byp_hit1 ? rf_wd : '0;
    assign byp_rd2  = byp_hit2 ? rf_wd : '0;
`endif

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (default params).
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [3:0]  starve_cnt;
`ifdef WB_ARBITER_BYPASS_EN
    logic [4:0]  byp_ra1, byp_ra2;
    logic [31:0] byp_rd1, byp_rd2;
    logic        byp_hit1, byp_hit2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
`ifdef WB_ARBITER_BYPASS_EN
        .byp_ra1    (byp_ra1),
        .byp_ra2    (byp_ra2),
        .byp_rd1    (byp_rd1),
        .byp_rd2    (byp_rd2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
`endif
        .starve_cnt (starve_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are then stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = v;
        lsu_rd    = rd;
        lsu_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        drive_alu(1'b1, 5'd5, 32'h1);
        drive_lsu(1'b1, 5'd6, 32'h2);
`ifdef WB_ARBITER_BYPASS_EN
        byp_ra1 = 5'd0;
        byp_ra2 = 5'd0;
`endif
        // Reset state, with requests present during reset.
        step();
        chk("rst_we", rf_we, 0);
        chk("rst_wa", rf_wa, 0);
        chk("rst_wd", rf_wd, 0);
        chk("rst_cnt", starve_cnt, 0);
        chk("rst_alu_rdy", alu_ready, 0);
        chk("rst_lsu_rdy", lsu_ready, 0);
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        rst = 1'b0;

        // Lone ALU request.
        drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("lone_alu_rdy", alu_ready, 1);
        chk("lone_lsu_rdy", lsu_ready, 0);
        step();
        chk("lone_we", rf_we, 1);
        chk("lone_wa", rf_wa, 5);
        chk("lone_wd", rf_wd, 32'hDEADBEEF);
        drive_alu(1'b0, 5'd0, 32'h0);
        #1;
        chk("idle_alu_rdy", alu_ready, 0);
        step();
        chk("idle_we", rf_we, 0);
        chk("idle_wa_hold", rf_wa, 5);
        chk("idle_wd_hold", rf_wd, 32'hDEADBEEF);

        // Collision: LSU first, ALU next cycle, back to back.
        drive_lsu(1'b1, 5'd3, 32'h11);
        drive_alu(1'b1, 5'd4, 32'h22);
        #1;
        chk("col_lsu_rdy", lsu_ready, 1);
        chk("col_alu_rdy", alu_ready, 0);
        step();
        chk("col1_we", rf_we, 1);
        chk("col1_wa", rf_wa, 3);
        chk("col1_wd", rf_wd, 32'h11);
        chk("col1_cnt", starve_cnt, 1);
        drive_lsu(1'b0, 5'd0, 32'h0);
        #1;
        chk("col2_alu_rdy", alu_ready, 1);
        step();
        chk("col2_we", rf_we, 1);
        chk("col2_wa", rf_wa, 4);
        chk("col2_wd", rf_wd, 32'h22);
        chk("col2_cnt", starve_cnt, 0);
        drive_alu(1'b0, 5'd0, 32'h0);
        step();
        chk("col3_we", rf_we, 0);

        // Starvation: four losses, forced grant on the fifth cycle.
        drive_lsu(1'b1, 5'd7, 32'h77);
        drive_alu(1'b1, 5'd9, 32'h99);
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("stv_alu_rdy", alu_ready, 0);
            chk("stv_lsu_rdy", lsu_ready, 1);
            step();
            chk("stv_cnt", starve_cnt, 32'(i));
            chk("stv_wa", rf_wa, 7);
        end
        #1;
        chk("stv5_alu_rdy", alu_ready, 1);
        chk("stv5_lsu_rdy", lsu_ready, 0);
        step();
        chk("stv5_wa", rf_wa, 9);
        chk("stv5_wd", rf_wd, 32'h99);
        chk("stv5_cnt", starve_cnt, 0);
        // Back in PRI_LSU: LSU wins the next collision.
        #1;
        chk("stv6_lsu_rdy", lsu_ready, 1);
        chk("stv6_alu_rdy", alu_ready, 0);

        // PRI_ALU is held while alu_valid is low.
        for (int i = 1; i <= 4; i++) step();
        chk("hold_cnt4", starve_cnt, 4);
        drive_alu(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_lsu_rdy", lsu_ready, 1);
            step();
            chk("hold_wa", rf_wa, 7);
            chk("hold_cnt0", starve_cnt, 0);
        end
        drive_alu(1'b1, 5'd9, 32'h98);
        #1;
        chk("hold_alu_wins", alu_ready, 1);
        chk("hold_lsu_loses", lsu_ready, 0);
        step();
        chk("hold_alu_wa", rf_wa, 9);
        chk("hold_alu_wd", rf_wd, 32'h98);
        #1;
        chk("hold_back_lsu", lsu_ready, 1);
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        step();

        // x0 writes: both accepted together, no register write.
        drive_alu(1'b1, 5'd0, 32'hAA);
        drive_lsu(1'b1, 5'd0, 32'hBB);
        #1;
        chk("x0_alu_rdy", alu_ready, 1);
        chk("x0_lsu_rdy", lsu_ready, 1);
        step();
        chk("x0_we", rf_we, 0);
        chk("x0_cnt", starve_cnt, 0);
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        step();

        // Reset in the middle of a grant cycle.
        drive_lsu(1'b1, 5'd3, 32'h33);
        drive_alu(1'b1, 5'd12, 32'hAB);
        step();
        chk("mrst_pre_we", rf_we, 1);
        chk("mrst_pre_cnt", starve_cnt, 1);
        drive_lsu(1'b0, 5'd0, 32'h0);
        #1;
        chk("mrst_grant_rdy", alu_ready, 1);
        rst = 1'b1;
        #1;
        chk("mrst_we", rf_we, 0);
        chk("mrst_wa", rf_wa, 0);
        chk("mrst_wd", rf_wd, 0);
        chk("mrst_cnt", starve_cnt, 0);
        chk("mrst_alu_rdy", alu_ready, 0);
        step();
        drive_alu(1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        step();
        chk("mrst_post_we", rf_we, 0);
        chk("mrst_post_cnt", starve_cnt, 0);
        // First grant possible right after release.
        drive_alu(1'b1, 5'd2, 32'h2);
        #1;
        chk("mrst_first_rdy", alu_ready, 1);
        step();
        chk("mrst_first_we", rf_we, 1);
        chk("mrst_first_wa", rf_wa, 2);
        drive_alu(1'b0, 5'd0, 32'h0);
        step();

`ifdef WB_ARBITER_BYPASS_EN
        // Bypass of the write being committed.
        drive_alu(1'b1, 5'd6, 32'h55);
        step();
        drive_alu(1'b0, 5'd0, 32'h0);
        byp_ra1 = 5'd6;
        byp_ra2 = 5'd0;
        #1;
        chk("byp_hit1", byp_hit1, 1);
        chk("byp_rd1", byp_rd1, 32'h55);
        chk("byp_hit2", byp_hit2, 0);
        chk("byp_rd2", byp_rd2, 0);
        step();
        chk("byp_nowe_hit1", byp_hit1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_arbiter
